filter2d_window: RTL and testbench

FILTER2D_WINDOW -- requirements
Module: filter2d_window

---
 rtl/filter2d_window_if.sv | 25 ++
 rtl/filter2d_window.sv | 156 +++++++++++++++
 tb/tb_filter2d_window.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/filter2d_window_if.sv
// Column-in / window-out bundle for filter2d_window.
// master drives columns and observes windows; slave is the window generator.
interface filter2d_window_if #(
   parameter int DIN_WIDTH = 8,
   parameter int WIN_SIZE  = 3
);
   logic                                          frame_start_buf;
   logic                                          din_vld_buf;
   logic [WIN_SIZE-1:0][DIN_WIDTH-1:0]            din_buf;
   logic                                          win_vld;
   logic                                          win_frame_start;
   logic                                          win_line_end;
   logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0] win;
   logic                                          ovf;

   modport master (
      output frame_start_buf, din_vld_buf, din_buf,
      input  win_vld, win_frame_start, win_line_end, win, ovf
   );

   modport slave (
      input  frame_start_buf, din_vld_buf, din_buf,
      output win_vld, win_frame_start, win_line_end, win, ovf
   );
endinterface

// File: rtl/filter2d_window.sv
// Builds zero-padded WIN_SIZE x WIN_SIZE windows from vertical pixel columns; window c appears 1 cycle after column c+WIN_R.
// No backpressure: each line ends with WIN_R flush cycles, and columns arriving then are dropped and flagged on ovf.
module filter2d_window #(
   parameter int FRAME_H   = 1080,
   parameter int FRAME_W   = 1920,
   parameter int DIN_WIDTH = 8,
   parameter int WIN_SIZE  = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   filter2d_window_if.slave bus
);
   localparam int WIN_R = WIN_SIZE / 2;
   localparam int CW    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int LW    = $clog2(FRAME_H + WIN_R);
   localparam int FW    = (WIN_R > 1) ? $clog2(WIN_R) : 1;

   localparam logic [CW-1:0] COL_FILL_LAST  = CW'(WIN_R - 1);
   localparam logic [CW-1:0] COL_FIRST_WIN  = CW'(WIN_R);
   localparam logic [CW-1:0] COL_LAST       = CW'(FRAME_W - 1);
   localparam logic [LW-1:0] LINE_FIRST_OUT = LW'(WIN_R);
   localparam logic [LW-1:0] LINE_LAST      = LW'(FRAME_H - 1 + WIN_R);
   localparam logic [FW-1:0] FLUSH_LAST     = FW'(WIN_R - 1);

   typedef logic [WIN_SIZE-1:0][DIN_WIDTH-1:0]               col_t;
   typedef logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0] win_t;
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

   state_t          state, state_nxt, st;
   logic [CW-1:0]   col, col_nxt, c;
   logic [LW-1:0]   line, line_nxt, l;
   logic [FW-1:0]   fcnt, fcnt_nxt;
   win_t            sr, sr_nxt, s, shifted;
   col_t            col_in, shift_in;
   logic            ovf, ovf_nxt;
   logic            emit, emit_fs, emit_le;
   win_t            win_q;
   logic            vld_q, fs_q, le_q;

   always_comb begin
      st       = state;
      c        = col;
      l        = line;
      s        = sr;
      ovf_nxt  = ovf;
      fcnt_nxt = fcnt;
      // A frame start overrides whatever is in flight and may carry column 0 itself.
      if (bus.frame_start_buf) begin
         st       = S_FILL;
         c        = '0;
         l        = '0;
         s        = '0;
         fcnt_nxt = '0;
         ovf_nxt  = 1'b0;
      end

      // Tap k carries input line l-k; lines outside the frame become zero padding.
      for (int k = 0; k < WIN_SIZE; k++) begin
         col_in[k] = ((int'(l) >= k) && (int'(l) - k < FRAME_H)) ? bus.din_buf[k] : '0;
      end
      shift_in = (st == S_FLUSH) ? '0 : col_in;

      for (int i = 0; i < WIN_SIZE; i++) begin
         for (int j = 0; j < WIN_SIZE - 1; j++) begin
            shifted[i][j] = s[i][j+1];
         end
         shifted[i][WIN_SIZE-1] = shift_in[i];
      end

      state_nxt = st;
      col_nxt   = c;
      line_nxt  = l;
      sr_nxt    = s;
      emit      = 1'b0;
      emit_fs   = 1'b0;
      emit_le   = 1'b0;

      unique case (st)
         S_IDLE: begin
         end
         S_FILL: begin
            if (bus.din_vld_buf) begin
               sr_nxt  = shifted;
               col_nxt = c + CW'(1);
               if (c == COL_FILL_LAST) state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.din_vld_buf) begin
               sr_nxt  = shifted;
               emit    = (l >= LINE_FIRST_OUT);
               emit_fs = emit && (l == LINE_FIRST_OUT) && (c == COL_FIRST_WIN);
               if (c == COL_LAST) begin
                  col_nxt   = '0;
                  fcnt_nxt  = '0;
                  state_nxt = S_FLUSH;
               end else begin
                  col_nxt = c + CW'(1);
               end
            end
         end
         S_FLUSH: begin
            ovf_nxt = ovf_nxt | bus.din_vld_buf;
            sr_nxt  = shifted;
            emit    = (l >= LINE_FIRST_OUT);
            if (fcnt == FLUSH_LAST) begin
               emit_le  = emit;
               sr_nxt   = '0;
               fcnt_nxt = '0;
               if (l == LINE_LAST) begin
                  state_nxt = S_IDLE;
                  line_nxt  = '0;
               end else begin
                  state_nxt = S_FILL;
                  line_nxt  = l + LW'(1);
               end
            end else begin
               fcnt_nxt = fcnt + FW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
         col   <= '0;
         line  <= '0;
         fcnt  <= '0;
         sr    <= '0;
         ovf   <= 1'b0;
         win_q <= '0;
         vld_q <= 1'b0;
         fs_q  <= 1'b0;
         le_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         line  <= line_nxt;
         fcnt  <= fcnt_nxt;
         sr    <= sr_nxt;
         ovf   <= ovf_nxt;
         vld_q <= emit;
         fs_q  <= emit_fs;
         le_q  <= emit_le;
         if (emit) win_q <= shifted;
      end
   end

   assign bus.win             = win_q;
   assign bus.win_vld         = vld_q;
   assign bus.win_frame_start = fs_q;
   assign bus.win_line_end    = le_q;
   assign bus.ovf             = ovf;
endmodule

// File: tb/tb_filter2d_window.sv
// Directed sequence with random images and gaps; windows checked against a raster-order reference built from the image.
module tb_filter2d_window;
   localparam int H  = 3;
   localparam int W  = 4;
   localparam int WS = 3;
   localparam int R  = WS / 2;
   localparam int DW = 8;
   localparam int WB = WS * WS * DW;

   typedef logic [WS-1:0][WS-1:0][DW-1:0] win_t;
   typedef struct {
      win_t w;
      logic fs;
      logic le;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;

   filter2d_window_if #(.DIN_WIDTH(DW), .WIN_SIZE(WS)) bus ();

   filter2d_window #(
      .FRAME_H(H), .FRAME_W(W), .DIN_WIDTH(DW), .WIN_SIZE(WS)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        expq[$];
   logic [DW-1:0] img [H][W];
   win_t        cap [H*W];
   int          nwin, nfs, nle;
   logic        exp_ovf;

   task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_pix(input int row, input int col);
      if (row < 0 || row >= H || col < 0 || col >= W) return '0;
      return img[row][col];
   endfunction

   // Every window of the frame in raster order, padded with zeros outside the image.
   task automatic load_expected();
      exp_t e;
      expq.delete();
      for (int r = 0; r < H; r++) begin
         for (int cc = 0; cc < W; cc++) begin
            for (int i = 0; i < WS; i++)
               for (int j = 0; j < WS; j++)
                  e.w[i][j] = ref_pix(r + R - i, cc + j - R);
            e.fs = (r == 0 && cc == 0);
            e.le = (cc == W - 1);
            expq.push_back(e);
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (bus.win_vld === 1'b1) begin
         if (nwin < H * W) cap[nwin] = bus.win;
         nwin++;
         if (bus.win_frame_start) nfs++;
         if (bus.win_line_end) nle++;
         if (expq.size() == 0) begin
            chk("spurious_vld", WB'(bus.win_vld), '0);
         end else begin
            e = expq.pop_front();
            chk("win", bus.win, e.w);
            chk("win_frame_start", WB'(bus.win_frame_start), WB'(e.fs));
            chk("win_line_end", WB'(bus.win_line_end), WB'(e.le));
         end
      end else begin
         chk("flags_without_vld", WB'({bus.win_frame_start, bus.win_line_end}), '0);
      end
      chk("ovf", WB'(bus.ovf), WB'(exp_ovf));
   endtask

   // Upstream line buffer: tap k is line L-k; rows outside the frame get junk the DUT must mask.
   task automatic put_col(input int L, input int cc);
      int row;
      for (int k = 0; k < WS; k++) begin
         row = L - k;
         bus.din_buf[k] = (row >= 0 && row < H) ? img[row][cc] : DW'($urandom);
      end
   endtask

   task automatic run_frame(input bit directed, input int gap_max, input bit fs_with_col,
                            input int ovf_line, input int abort_after);
      int acc;
      int nb;
      acc = 0;
      for (int r = 0; r < H; r++)
         for (int cc = 0; cc < W; cc++)
            img[r][cc] = directed ? DW'(16 * r + cc) : DW'($urandom);
      load_expected();
      nwin = 0; nfs = 0; nle = 0;
      if (!fs_with_col) begin
         exp_ovf = 1'b0;
         bus.frame_start_buf = 1'b1;
         tick();
         bus.frame_start_buf = 1'b0;
      end
      for (int L = 0; L < H + R; L++) begin
         for (int cc = 0; cc < W; cc++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            put_col(L, cc);
            bus.din_vld_buf = 1'b1;
            bus.frame_start_buf = fs_with_col && L == 0 && cc == 0;
            if (bus.frame_start_buf) exp_ovf = 1'b0;
            tick();
            bus.din_vld_buf = 1'b0;
            bus.frame_start_buf = 1'b0;
            acc++;
            if (acc == abort_after) return;
         end
         nb = R + ((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
         for (int b = 0; b < nb; b++) begin
            if (L == ovf_line && b == 0) begin
               put_col(L, 0);
               bus.din_vld_buf = 1'b1;
               exp_ovf = 1'b1;
            end
            tick();
            bus.din_vld_buf = 1'b0;
         end
      end
      repeat (3) tick();
      chk("window_count", WB'(nwin), WB'(H * W));
      chk("frame_start_count", WB'(nfs), WB'(1));
      chk("line_end_count", WB'(nle), WB'(H));
      chk("windows_left", WB'(expq.size()), '0);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.frame_start_buf = 1'b0;
      bus.din_vld_buf = 1'b0;
      bus.din_buf = '0;
      exp_ovf = 1'b0;
      nwin = 0; nfs = 0; nle = 0;

      repeat (3) tick();
      chk("rst_win_vld", WB'(bus.win_vld), '0);
      chk("rst_win", bus.win, '0);
      chk("rst_ovf", WB'(bus.ovf), '0);
      reset_n = 1'b1;
      tick();

      // Directed image, continuous columns, fs together with the first column.
      run_frame(1'b1, 0, 1'b1, -1, -1);
      chk("c00_bottom_row", WB'(cap[0][2]), '0);
      chk("c00_left_col", WB'({cap[0][0][0], cap[0][1][0], cap[0][2][0]}), '0);
      chk("c00_centre", WB'(cap[0][1][1]), WB'(8'h00));
      chk("c00_win02", WB'(cap[0][0][2]), WB'(8'h11));
      chk("c23_top_tap_row", WB'(cap[H*W-1][0]), '0);
      chk("c23_right_col", WB'({cap[H*W-1][0][2], cap[H*W-1][1][2], cap[H*W-1][2][2]}), '0);
      chk("c23_centre", WB'(cap[H*W-1][1][1]), WB'(8'h23));

      // Columns while idle are ignored.
      for (int n = 0; n < 4; n++) begin
         put_col(0, n);
         bus.din_vld_buf = 1'b1;
         tick();
         chk("idle_no_vld", WB'(bus.win_vld), '0);
      end
      bus.din_vld_buf = 1'b0;

      // Column injected during the flush of line 1 is dropped and sets ovf.
      run_frame(1'b1, 0, 1'b0, 1, -1);
      chk("ovf_sticky", WB'(bus.ovf), WB'(1'b1));

      // Partial frame (with ovf) aborted by a new frame start.
      run_frame(1'b0, 0, 1'b1, 0, 6);
      chk("ovf_before_abort", WB'(bus.ovf), WB'(1'b1));
      run_frame(1'b0, 0, 1'b1, -1, -1);

      // Reset in the middle of a row.
      run_frame(1'b1, 0, 1'b1, -1, 10);
      reset_n = 1'b0;
      expq.delete();
      exp_ovf = 1'b0;
      tick();
      chk("mid_rst_vld", WB'(bus.win_vld), '0);
      chk("mid_rst_win", bus.win, '0);
      chk("mid_rst_flags", WB'({bus.win_frame_start, bus.win_line_end}), '0);
      reset_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         put_col(2, n % W);
         bus.din_vld_buf = 1'b1;
         tick();
         chk("post_rst_no_vld", WB'(bus.win_vld), '0);
      end
      bus.din_vld_buf = 1'b0;

      // Random images with random gaps and extra blanking.
      run_frame(1'b0, 3, 1'b0, -1, -1);
      run_frame(1'b0, 3, 1'b1, -1, -1);
      run_frame(1'b1, 2, 1'b0, -1, -1);
      run_frame(1'b0, 0, 1'b0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
